// File: rtl/issue_scheduler.sv
// -----------------------------------------------------------------------------
// issue_scheduler
//
// Decides each cycle whether the decoded control word may enter EX. Under a
// read-after-write hazard the word stays at the decoder and a bubble enters EX.
// It also moves the EX/MEM/WB control words down the pipe every cycle.
//
// Ports
//   clk          rising-edge clock for all state
//   rst_n        synchronous active-low reset
//   dec_valid    decoder presents a control word this cycle
//   dec_ctrl     22-bit control word:
//                  [21:17] srcA  [16:12] srcB  [11] B/IMM  [10] ALU/MUL
//                  [9:8] alu_op  [7] mem wr  [6] WB mux  [5:1] dst  [0] rf write
//   flush        discard the presented word and insert a bubble this cycle
//   dec_ready    (comb) the presented word can issue this cycle
//   ex_ctrl      registered control word of the EX stage
//   mem_ctrl     registered control word of the MEM stage
//   wb_ctrl      registered control word of the WB stage
//   stall        (comb) a valid word is being held back by a hazard
//   stall_count  saturating count of stall cycles
//
// Handshake: a word issues on a rising edge where dec_valid & dec_ready are
// both high. dec_ready does not look at dec_valid. While dec_ready is low, the
// upstream keeps dec_valid and dec_ctrl stable. This block keeps no copy of an
// unissued word.
// -----------------------------------------------------------------------------
module issue_scheduler #(
  parameter int CHECK_WB = 1,   // 1: WB stage is hazard-checked (no RF write-through)
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic [21:0]      dec_ctrl,
  input  logic             flush,
  output logic             dec_ready,
  output logic [21:0]      ex_ctrl,
  output logic [21:0]      mem_ctrl,
  output logic [21:0]      wb_ctrl,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  logic [21:0]      r_ex;
  logic [21:0]      r_mem;
  logic [21:0]      r_wb;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [4:0] w_src_a;
  logic [4:0] w_src_b;
  logic       w_ex_hit;
  logic       w_mem_hit;
  logic       w_wb_hit;
  logic       w_hazard;
  logic       w_issue;
  logic       w_stall;

  assign w_src_a = dec_ctrl[21:17];
  assign w_src_b = dec_ctrl[16:12];

  // A stage hits only if it writes the RF (bit 0) and a nonzero source names
  // its dst. A dst of 0 never hits, because a hit needs a nonzero source.
  always_comb begin
    w_ex_hit  = 1'b0;
    w_mem_hit = 1'b0;
    w_wb_hit  = 1'b0;
    if (r_ex[0]) begin
      w_ex_hit = ((w_src_a != 5'd0) && (w_src_a == r_ex[5:1])) ||
                 ((w_src_b != 5'd0) && (w_src_b == r_ex[5:1]));
    end
    if (r_mem[0]) begin
      w_mem_hit = ((w_src_a != 5'd0) && (w_src_a == r_mem[5:1])) ||
                  ((w_src_b != 5'd0) && (w_src_b == r_mem[5:1]));
    end
    if (r_wb[0]) begin
      w_wb_hit = ((w_src_a != 5'd0) && (w_src_a == r_wb[5:1])) ||
                 ((w_src_b != 5'd0) && (w_src_b == r_wb[5:1]));
    end
  end

  assign w_hazard = w_ex_hit || w_mem_hit || ((CHECK_WB != 0) && w_wb_hit);
  // Flush wins over a hazard, so a flushed cycle never counts as a stall.
  assign dec_ready = !w_hazard && !flush;
  assign w_issue   = dec_valid && dec_ready;
  assign w_stall   = dec_valid && w_hazard && !flush;
  assign stall     = w_stall;

  // The stages never hold. A word that does not issue leaves a NOP in EX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex        <= 22'h0;
      r_mem       <= 22'h0;
      r_wb        <= 22'h0;
      r_stall_cnt <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_issue ? dec_ctrl : 22'h0;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign ex_ctrl     = r_ex;
  assign mem_ctrl    = r_mem;
  assign wb_ctrl     = r_wb;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_issue_scheduler
//
// Two instances share one set of inputs:
//   u_dut0  CHECK_WB=1, CNT_W=16
//   u_dut1  CHECK_WB=0, CNT_W=4
// Only the selected instance (sel) is checked. A reference model tracks the
// three in-flight words as an array. It decides hazards from the field rules.
// -----------------------------------------------------------------------------
module tb_issue_scheduler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        dec_valid;
  logic [21:0] dec_ctrl;
  logic        flush;

  logic        ready0, stall0, ready1, stall1;
  logic [21:0] ex0, mem0, wb0, ex1, mem1, wb1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  issue_scheduler #(.CHECK_WB(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ctrl(dec_ctrl),
    .flush(flush), .dec_ready(ready0), .ex_ctrl(ex0), .mem_ctrl(mem0),
    .wb_ctrl(wb0), .stall(stall0), .stall_count(cnt0)
  );

  issue_scheduler #(.CHECK_WB(0), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ctrl(dec_ctrl),
    .flush(flush), .dec_ready(ready1), .ex_ctrl(ex1), .mem_ctrl(mem1),
    .wb_ctrl(wb1), .stall(stall1), .stall_count(cnt1)
  );

  bit sel;  // 0 = u_dut0, 1 = u_dut1
  logic        o_ready, o_stall;
  logic [21:0] o_ex, o_mem, o_wb;
  logic [15:0] o_cnt;
  assign o_ready = sel ? ready1 : ready0;
  assign o_stall = sel ? stall1 : stall0;
  assign o_ex    = sel ? ex1 : ex0;
  assign o_mem   = sel ? mem1 : mem0;
  assign o_wb    = sel ? wb1 : wb0;
  assign o_cnt   = sel ? {12'h0, cnt1} : cnt0;

  // ---------------- scoreboard / check ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
    end
  endtask

  // ---------------- reference model ----------------
  logic [21:0] m_pipe[3];   // index 0 = EX, 1 = MEM, 2 = WB
  int          m_cnt;
  bit          last_ready_low;

  function automatic bit m_check_wb();
    return (sel == 1'b0);
  endfunction

  function automatic int m_cnt_max();
    return sel ? 15 : 65535;
  endfunction

  function automatic bit m_hazard(input logic [21:0] w);
    int srcs[2];
    srcs[0] = int'(w[21:17]);
    srcs[1] = int'(w[16:12]);
    for (int k = 0; k < 3; k++) begin
      if (k == 2 && !m_check_wb()) continue;
      if (m_pipe[k][0] == 1'b1) begin
        for (int s = 0; s < 2; s++) begin
          if (srcs[s] != 0 && srcs[s] == int'(m_pipe[k][5:1])) return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [21:0] mk(input int a, input int b, input int d, input bit wr);
    logic [21:0] w;
    w        = 22'($urandom);
    w[21:17] = 5'(a);
    w[16:12] = 5'(b);
    w[5:1]   = 5'(d);
    w[0]     = wr;
    return w;
  endfunction

  // ---------------- driver ----------------
  // One cycle: drive the inputs, check the combinational outputs at the
  // negedge, advance the model at the posedge, then check the registers.
  task automatic step(input bit v, input logic [21:0] c, input bit f, input bit r,
                      output bit issued);
    bit hz, e_ready, e_stall;
    dec_valid = v;
    dec_ctrl  = c;
    flush     = f;
    rst_n     = r;
    issued    = 1'b0;
    @(negedge clk);
    hz      = m_hazard(c);
    e_ready = !hz && !f;
    e_stall = v && hz && !f;
    check_val("dec_ready", 32'(o_ready), 32'(e_ready));
    check_val("stall", 32'(o_stall), 32'(e_stall));
    last_ready_low = !o_ready;
    @(posedge clk);
    if (!r) begin
      m_pipe[0] = '0; m_pipe[1] = '0; m_pipe[2] = '0;
      m_cnt = 0;
    end else begin
      issued    = v && e_ready;
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = issued ? c : 22'h0;
      if (e_stall && m_cnt < m_cnt_max()) m_cnt++;
    end
    #1;
    check_val("ex_ctrl", 32'(o_ex), 32'(m_pipe[0]));
    check_val("mem_ctrl", 32'(o_mem), 32'(m_pipe[1]));
    check_val("wb_ctrl", 32'(o_wb), 32'(m_pipe[2]));
    check_val("stall_count", 32'(o_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    bit iss;
    step(1'b0, 22'h0, 1'b0, 1'b0, iss);
  endtask

  // Presents w until it issues (bounded). Returns the number of cycles the DUT
  // showed dec_ready low.
  task automatic present_until_issue(input logic [21:0] w, input string tag, output int lows);
    bit iss;
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, w, 1'b0, 1'b1, iss);
      if (last_ready_low) lows++;
      if (iss) return;
    end
    check_val({tag, "_issue_timeout"}, 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  task automatic random_phase(input int cycles);
    bit have, iss, r, f, v;
    logic [21:0] w;
    have = 1'b0;
    w    = 22'h0;
    for (int i = 0; i < cycles; i++) begin
      r = ($urandom_range(0, 49) != 0);
      f = ($urandom_range(0, 7) == 0);
      if (!have) begin
        w    = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        v    = ($urandom_range(0, 3) != 0);
        have = v;
      end
      step(have, w, f, r, iss);
      if (iss || f || !r) have = 1'b0;
    end
  endtask

  initial begin
    bit iss;
    int lows;
    logic [21:0] w1, w2, w3;

    sel       = 1'b0;
    rst_n     = 1'b0;
    dec_valid = 1'b0;
    dec_ctrl  = 22'h0;
    flush     = 1'b0;
    m_pipe[0] = '0; m_pipe[1] = '0; m_pipe[2] = '0;
    m_cnt     = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_ex", 32'(o_ex), 32'd0);
    check_val("reset_cnt", 32'(o_cnt), 32'd0);

    // RAW stall, WB checked: 3 stall cycles.
    step(1'b1, mk(1, 2, 3, 1'b1), 1'b0, 1'b1, iss);
    present_until_issue(mk(3, 0, 7, 1'b1), "raw_wb1", lows);
    check_val("raw_stalls_wb1", 32'(lows), 32'd3);
    check_val("raw_count_wb1", 32'(o_cnt), 32'd3);

    // Non-hazards: write to r0 then read r0; store with wr=0 then read r5.
    do_reset();
    step(1'b1, mk(0, 0, 0, 1'b1), 1'b0, 1'b1, iss);
    step(1'b1, mk(0, 0, 9, 1'b1), 1'b0, 1'b1, iss);
    check_val("r0_no_stall", 32'(iss), 32'd1);
    step(1'b1, mk(4, 5, 5, 1'b0), 1'b0, 1'b1, iss);
    step(1'b1, mk(5, 5, 8, 1'b1), 1'b0, 1'b1, iss);
    check_val("store_no_stall", 32'(iss), 32'd1);

    // Flush during a stall: bubble into EX, MEM takes the old EX, count held.
    do_reset();
    step(1'b1, mk(0, 0, 6, 1'b1), 1'b0, 1'b1, iss);
    w1 = mk(6, 0, 2, 1'b1);
    step(1'b1, w1, 1'b0, 1'b1, iss);   // stalls on EX
    step(1'b1, w1, 1'b1, 1'b1, iss);   // flush
    check_val("flush_ex_bubble", 32'(o_ex), 32'd0);
    check_val("flush_cnt_held", 32'(o_cnt), 32'd1);

    // Pipeline advance, then reset mid-operation.
    do_reset();
    w1 = mk(0, 0, 10, 1'b1);
    w2 = mk(0, 0, 11, 1'b1);
    w3 = mk(0, 0, 12, 1'b1);
    step(1'b1, w1, 1'b0, 1'b1, iss);
    step(1'b1, w2, 1'b0, 1'b1, iss);
    step(1'b1, w3, 1'b0, 1'b1, iss);
    check_val("adv_wb_w1", 32'(o_wb), 32'(w1));
    check_val("adv_mem_w2", 32'(o_mem), 32'(w2));
    check_val("adv_ex_w3", 32'(o_ex), 32'(w3));
    step(1'b0, 22'h0, 1'b0, 1'b1, iss);
    check_val("adv_ex_nop", 32'(o_ex), 32'd0);
    step(1'b1, w1, 1'b0, 1'b1, iss);
    step(1'b1, w2, 1'b0, 1'b1, iss);
    step(1'b1, mk(10, 11, 1, 1'b1), 1'b0, 1'b0, iss);  // reset edge
    check_val("rst_mid_ex", 32'(o_ex), 32'd0);
    step(1'b1, mk(10, 11, 12, 1'b1), 1'b0, 1'b1, iss);
    check_val("rst_ready_after", 32'(iss), 32'd1);

    random_phase(300);

    // CHECK_WB=0, CNT_W=4 instance.
    sel = 1'b1;
    do_reset();
    step(1'b1, mk(1, 2, 3, 1'b1), 1'b0, 1'b1, iss);
    present_until_issue(mk(3, 0, 7, 1'b1), "raw_wb0", lows);
    check_val("raw_stalls_wb0", 32'(lows), 32'd2);

    // Saturation: repeated writer/reader pairs accumulate 20 stall cycles.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, mk(0, 0, 1, 1'b1), 1'b0, 1'b1, iss);
      present_until_issue(mk(1, 0, 0, 1'b0), "sat", lows);
    end
    check_val("sat_cnt_F", 32'(o_cnt), 32'hF);
    step(1'b1, mk(0, 0, 1, 1'b1), 1'b0, 1'b1, iss);
    present_until_issue(mk(1, 0, 0, 1'b0), "sat2", lows);
    check_val("sat_cnt_stays_F", 32'(o_cnt), 32'hF);

    random_phase(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
